// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and total-length helper
package vga_pkg;

  // 800x600 @ 60 Hz (40 MHz pixel clock)
  localparam int VGA800_H_VISIBLE = 800;
  localparam int VGA800_H_FP      = 40;
  localparam int VGA800_H_SYNC    = 128;
  localparam int VGA800_H_BP      = 88;
  localparam int VGA800_V_VISIBLE = 600;
  localparam int VGA800_V_FP      = 1;
  localparam int VGA800_V_SYNC    = 4;
  localparam int VGA800_V_BP      = 23;

  // Legacy 200x150 mode: the 800x600 line scaled down by four
  localparam int VGA200_H_VISIBLE = 200;
  localparam int VGA200_H_FP      = 10;
  localparam int VGA200_H_SYNC    = 32;
  localparam int VGA200_H_BP      = 22;
  localparam int VGA200_V_VISIBLE = 150;
  localparam int VGA200_V_FP      = 1;
  localparam int VGA200_V_SYNC    = 1;
  localparam int VGA200_V_BP      = 5;

  localparam int VGA_CNT_W = 11;

  function automatic int vga_total(input int visible, input int fp,
                                   input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrapping position counter with registered active/sync decode
module vga_axis_cnt #(
  parameter int TOTAL   = 1056,
  parameter int VISIBLE = 800,
  parameter int FP      = 40,
  parameter int SYNC    = 128,
  parameter bit POL     = 1'b1,
  parameter int CNT_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS     = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VISIBLE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VISIBLE + FP + SYNC);

  logic [CNT_W-1:0] count_nxt;

  assign wrap      = (count == LAST);
  assign count_nxt = wrap ? '0 : count + 1'b1;

  // Decode from the next count so active/sync move on the same edge as count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= LAST;
      active <= 1'b0;
      sync   <= ~POL;
    end else if (advance) begin
      count  <= count_nxt;
      active <= (count_nxt < VIS);
      sync   <= ((count_nxt >= SYNC_LO) && (count_nxt < SYNC_HI)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator; VGA_TIMING_FRAME_CNT_EN adds frame_count
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA800_H_VISIBLE,
  parameter int H_FP      = VGA800_H_FP,
  parameter int H_SYNC    = VGA800_H_SYNC,
  parameter int H_BP      = VGA800_H_BP,
  parameter int V_VISIBLE = VGA800_V_VISIBLE,
  parameter int V_FP      = VGA800_V_FP,
  parameter int V_SYNC    = VGA800_V_SYNC,
  parameter int V_BP      = VGA800_V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int PIX_DIV   = 1,
  parameter int CNT_W     = VGA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             pixel_tick,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             display,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int H_TOTAL = vga_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] divider;
  logic             advance;
  logic             h_wrap, v_wrap;
  logic             h_active, v_active;

  assign advance = run && (divider == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divider <= '0;
    end else if (run) begin
      divider <= advance ? '0 : divider + 1'b1;
    end
  end

  vga_axis_cnt #(
    .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC),
    .POL(HSYNC_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .advance(advance),
    .count(hcount), .wrap(h_wrap), .active(h_active), .sync(hsync)
  );

  // Vertical axis only steps on the advance that wraps the line
  vga_axis_cnt #(
    .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC),
    .POL(VSYNC_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .advance(advance && h_wrap),
    .count(vcount), .wrap(v_wrap), .active(v_active), .sync(vsync)
  );

  assign display = h_active && v_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= advance;
      line_start  <= advance && h_wrap;
      frame_start <= advance && h_wrap && v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (advance && h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
